mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single AXI transaction engine between three requesters:
//  dcache line fill/writeback, uncached data (data_sram), and icache line fill.
//  Grants one requester at a time and latches its command. Holds the grant until
//  the engine reports completion or a timeout fires, then routes done/err back.
//  Sits between the cache/uncache controllers and the axi line/burst engine.
// PARAMETERS
//  NREQ        3     number of requesters; index 0=dcache, 1=uncached, 2=icache
//  TIMEOUT     1023  max cycles in WAIT before abort; 10-bit counter
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  aresetn     in   1       asynchronous active-low reset
//  req_valid   in   NREQ    per-requester command valid
//  req_wr      in   NREQ    1=write, 0=read
//  req_addr    in   NREQ*32 physical address, requester i at [32*i+:32]
//  req_len     in   NREQ*4  AXI len (beats-1), [4*i+:4]
//  req_size    in   NREQ*3  AXI size, [3*i+:3]
//  req_ready   out  NREQ    one-hot pulse: command of requester i accepted
//  req_done    out  NREQ    one-hot pulse: transaction of requester i finished
//  req_err     out  NREQ    one-hot pulse with req_done on timeout abort
//  grant_oh    out  NREQ    one-hot owner, for external data-beat muxing
//  bus_valid   out  1       command valid to engine
//  bus_wr      out  1       latched req_wr
//  bus_addr    out  32      latched req_addr
//  bus_len     out  4       latched req_len
//  bus_size    out  3       latched req_size
//  bus_id      out  4       owner index, zero-extended (used as arid/awid)
//  bus_ready   in   1       engine accepts command (valid&ready handshake)
//  bus_done    in   1       engine finished last beat / write response
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0. Latched command 0. Timeout counter 0.
//    RR pointer is 0.
//  - FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  - IDLE: if any req_valid, select winner. Latch its command and set grant_oh.
//    Pulse req_ready[winner] the same cycle. Next state ISSUE.
//  - ISSUE: bus_valid=1 with latched fields stable. Stay until bus_ready=1.
//    On bus_ready go to WAIT; timeout counter cleared.
//  - WAIT: bus_valid=0. Count cycles.
//    - bus_done=1: pulse req_done[owner] and go to IDLE.
//    - Counter reaches TIMEOUT: pulse req_done[owner] and req_err[owner],
//      then go to IDLE.
//    - bus_done together with the timeout in the same cycle: done wins,
//      no err.
//  - grant_oh holds from the IDLE accept cycle up to and including the done
//    cycle. It clears in the following IDLE.
//  - Minimum grant-to-grant spacing is 3 cycles. A bus_done arriving in ISSUE
//    is ignored.
//  - Requester inputs are sampled only in IDLE. Later changes do not affect
//    the active command. A requester dropping req_valid after req_ready is legal.
//  - No overlap: at most one outstanding transaction; done is never routed to a
//    non-owner.
//  - Reset asserted mid-transaction: return to IDLE immediately, no done pulse.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN
//  - Defined: round-robin arbitration. Search starts at (last winner+1) mod NREQ.
//    The pointer updates on each accept.
//  - Undefined: fixed priority 0 > 1 > 2 (dcache first). No pointer state.
// TESTING
//  1. All three req_valid at once in IDLE, fixed priority -> req_ready=3'b001,
//     bus_id=0; then 2, then 4 on successive grants.
//  2. Same as 1 with MEM_ARB_ROUND_ROBIN_EN -> grant order 0,1,2. Then keep only
//     req 0 and 2 valid -> order continues 0,2,0,2.
//  3. Single icache read addr=32'h1FC0_0040 len=7, bus_ready held low 5 cycles
//     -> bus_valid high 5+1 cycles with constant fields; done pulse on
//     req_done[2] only.
//  4. Grant req 1, never assert bus_done -> exactly TIMEOUT cycles in WAIT, then
//     req_done[1]=req_err[1]=1 for one cycle, state IDLE.
//  5. bus_done on the timeout cycle -> req_done pulse, req_err stays 0.
//  6. aresetn low during WAIT -> all outputs 0 asynchronously, no req_done. After
//     release a pending req_valid is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single AXI transaction engine between the
// dcache (0), uncached data path (1) and icache (2). One command in flight;
// the owner keeps the grant until the engine reports done or the WAIT-state
// timeout aborts the transaction.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin arbitration;
// fixed priority 0 > 1 > 2 when undefined).
module mem_port_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*4-1:0]    req_len,
  input  logic [NREQ*3-1:0]    req_size,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [NREQ-1:0]      grant_oh,
  output logic                 bus_valid,
  output logic                 bus_wr,
  output logic [31:0]          bus_addr,
  output logic [3:0]           bus_len,
  output logic [2:0]           bus_size,
  output logic [3:0]           bus_id,
  input  logic                 bus_ready,
  input  logic                 bus_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]      state;
  logic [IW-1:0]   owner_idx;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] owner_oh;
  logic [CW-1:0]   cnt;
  logic            timeout_hit;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0]   rr_ptr;
`endif

  // Pick the winner among valid requesters (rotating or fixed search order)
  always_comb begin
    logic [IW:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
`else
      cand = (IW+1)'(k);
`endif
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  assign win_oh      = win_found ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx) : '0;
  assign owner_oh    = {{(NREQ-1){1'b0}}, 1'b1} << owner_idx;
  assign timeout_hit = (cnt == CW'(TIMEOUT));
  assign bus_id      = 4'(owner_idx);

  // Handshake and completion routing; done beats a coincident timeout.
  // The accept pulse is masked while reset is held so every output reads 0.
  always_comb begin
    req_ready = '0;
    req_done  = '0;
    req_err   = '0;
    grant_oh  = '0;
    bus_valid = 1'b0;
    case (state)
      IDLE: begin
        if (aresetn) begin
          req_ready = win_oh;
          grant_oh  = win_oh;
        end
      end
      ISSUE: begin
        grant_oh  = owner_oh;
        bus_valid = 1'b1;
      end
      WAIT: begin
        grant_oh = owner_oh;
        if (bus_done) begin
          req_done = owner_oh;
        end else if (timeout_hit) begin
          req_done = owner_oh;
          req_err  = owner_oh;
        end
      end
      default: ;
    endcase
  end

  // FSM, command latch, timeout counter and arbitration pointer
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      owner_idx <= '0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_len   <= '0;
      bus_size  <= '0;
      cnt       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            owner_idx <= win_idx;
            bus_wr    <= req_wr[win_idx];
            bus_addr  <= req_addr[32*win_idx +: 32];
            bus_len   <= req_len[4*win_idx +: 4];
            bus_size  <= req_size[3*win_idx +: 3];
            state     <= ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr    <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
`endif
          end
        end
        ISSUE: begin
          if (bus_ready) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus_done || timeout_hit) state <= IDLE;
          else                         cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
